// File: rtl/dp_pkg.sv
// dp_pkg
//   Shared definitions between the datapath and the microcoded controller:
//   strobe bit positions, bus source codes and ALU operation codes.
package dp_pkg;

    // Bit positions inside write_en / inc_en / clr_en.
    localparam int DP_PC    = 1;
    localparam int DP_AR    = 2;
    localparam int DP_IR    = 3;
    localparam int DP_AC    = 4;
    localparam int DP_R     = 5;
    localparam int DP_R4    = 7;
    localparam int DP_R3    = 8;
    localparam int DP_R2    = 9;
    localparam int DP_R1    = 10;
    localparam int DP_DM    = 11;
    localparam int DP_ALU   = 12;
    localparam int DP_LATCH = 14;

    // Bus source codes carried on read_en.
    typedef enum logic [3:0] {
        SRC_NONE = 4'd0,
        SRC_PC   = 4'd1,
        SRC_AR   = 4'd2,
        SRC_IR   = 4'd4,
        SRC_AC   = 4'd5,
        SRC_R    = 4'd6,
        SRC_R1   = 4'd7,
        SRC_R2   = 4'd8,
        SRC_R3   = 4'd9,
        SRC_R4   = 4'd10,
        SRC_DM   = 4'd12,
        SRC_IM   = 4'd13
    } src_e;

    // ALU operation codes carried on alu_op.
    typedef enum logic [2:0] {
        ALU_PASS   = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_MULT   = 3'd3,
        ALU_LSHIFT = 3'd4
    } alu_op_e;

endpackage : dp_pkg

// File: rtl/dp_reg.sv
// dp_reg
//   Generic datapath register with clear / load / increment strobes.
//   Priority on each posedge: clr (to 0) > we (load d) > inc (+1, wraps).
// Ports
//   clk    in  1  clock, state updates on posedge
//   rst_n  in  1  synchronous active-low reset
//   clr    in  1  clear strobe
//   we     in  1  load strobe
//   inc    in  1  increment strobe
//   d      in  W  load data (from the shared bus)
//   q      out W  register contents
module dp_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         we,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next-state selection with clr > we > inc priority.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (we) begin
            q_d = d;
        end else if (inc) begin
            q_d = q_q + W'(1'b1);
        end else begin
            q_d = q_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : dp_reg

// File: rtl/datapath_bus.sv
// datapath_bus
//   Datapath driven by the microcoded controller. Holds PC, AR, IR, AC, R and
//   R1-R4, a combinational shared bus, and a two-stage ALU (operand latch, then
//   result into AC). The controller changes strobes on negedge, so they are
//   stable well before the posedge at which this block registers.
// Ports
//   clk          in   1    clock, all state on posedge
//   rst_n        in   1    synchronous active-low reset
//   read_en      in   4    bus source select
//   write_en     in   16   per-target load strobes
//   inc_en       in   16   per-target increment strobes
//   clr_en       in   16   per-target clear strobes
//   alu_op       in   3    ALU operation
//   im_addr      out  PCW  instruction memory address (PC)
//   im_rdata     in   DW   instruction memory read data
//   dm_addr      out  AW   data memory address (AR)
//   dm_wdata     out  DW   data memory write data (the bus)
//   dm_we        out  1    data memory write strobe
//   dm_rdata     in   DW   data memory read data
//   instruction  out  6    opcode field ir[5:0]
//   z            out  16   1 when AC is zero, else 0
module datapath_bus
    import dp_pkg::*;
#(
    parameter int DW  = 16,
    parameter int PCW = 8,
    parameter int AW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      read_en,
    input  logic [15:0]     write_en,
    input  logic [15:0]     inc_en,
    input  logic [15:0]     clr_en,
    input  logic [2:0]      alu_op,
    output logic [PCW-1:0]  im_addr,
    input  logic [DW-1:0]   im_rdata,
    output logic [AW-1:0]   dm_addr,
    output logic [DW-1:0]   dm_wdata,
    output logic            dm_we,
    input  logic [DW-1:0]   dm_rdata,
    output logic [5:0]      instruction,
    output logic [15:0]     z
);

    logic [DW-1:0]   bus_s;
    logic [PCW-1:0]  pc_q;
    logic [AW-1:0]   ar_q;
    logic [DW-1:0]   ir_q;
    logic [DW-1:0]   r_q;
    logic [DW-1:0]   r1_q;
    logic [DW-1:0]   r2_q;
    logic [DW-1:0]   r3_q;
    logic [DW-1:0]   r4_q;
    logic [DW-1:0]   ac_q;
    logic [DW-1:0]   ac_d;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;
    logic [DW-1:0]   alu_res_s;
    logic [2*DW-1:0] mult_full_s;

    // Strobe bits with no target in this datapath; kept visible so the
    // ignored positions are an explicit decision.
    logic unused_strobes_s;
    assign unused_strobes_s = ^{write_en[15], write_en[13], write_en[6], write_en[0],
                                inc_en[15:11], inc_en[6], inc_en[0],
                                clr_en[15:11], clr_en[6], clr_en[0]};

    // Shared bus source mux; unassigned codes drive zero.
    always_comb begin
        bus_s = '0;
        case (src_e'(read_en))
            SRC_NONE: bus_s = '0;
            SRC_PC:   bus_s = DW'(pc_q);
            SRC_AR:   bus_s = DW'(ar_q);
            SRC_IR:   bus_s = ir_q;
            SRC_AC:   bus_s = ac_q;
            SRC_R:    bus_s = r_q;
            SRC_R1:   bus_s = r1_q;
            SRC_R2:   bus_s = r2_q;
            SRC_R3:   bus_s = r3_q;
            SRC_R4:   bus_s = r4_q;
            SRC_DM:   bus_s = dm_rdata;
            SRC_IM:   bus_s = im_rdata;
            default:  bus_s = '0;
        endcase
    end

    // Bus-loaded registers (AC is separate because of its ALU input).
    dp_reg #(.W(PCW)) u_pc (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_PC]), .we (write_en[DP_PC]), .inc (inc_en[DP_PC]),
        .d (bus_s[PCW-1:0]), .q (pc_q)
    );
    dp_reg #(.W(AW)) u_ar (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_AR]), .we (write_en[DP_AR]), .inc (inc_en[DP_AR]),
        .d (bus_s[AW-1:0]), .q (ar_q)
    );
    dp_reg #(.W(DW)) u_ir (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_IR]), .we (write_en[DP_IR]), .inc (inc_en[DP_IR]),
        .d (bus_s), .q (ir_q)
    );
    dp_reg #(.W(DW)) u_r (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_R]), .we (write_en[DP_R]), .inc (inc_en[DP_R]),
        .d (bus_s), .q (r_q)
    );
    dp_reg #(.W(DW)) u_r1 (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_R1]), .we (write_en[DP_R1]), .inc (inc_en[DP_R1]),
        .d (bus_s), .q (r1_q)
    );
    dp_reg #(.W(DW)) u_r2 (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_R2]), .we (write_en[DP_R2]), .inc (inc_en[DP_R2]),
        .d (bus_s), .q (r2_q)
    );
    dp_reg #(.W(DW)) u_r3 (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_R3]), .we (write_en[DP_R3]), .inc (inc_en[DP_R3]),
        .d (bus_s), .q (r3_q)
    );
    dp_reg #(.W(DW)) u_r4 (
        .clk (clk), .rst_n (rst_n),
        .clr (clr_en[DP_R4]), .we (write_en[DP_R4]), .inc (inc_en[DP_R4]),
        .d (bus_s), .q (r4_q)
    );

    // Full-width product so the truncation to DW bits is explicit.
    assign mult_full_s = {{DW{1'b0}}, alu_a_q} * {{DW{1'b0}}, alu_b_q};

    // ALU result from the latched operands; undefined op codes pass B.
    always_comb begin
        alu_res_s = alu_b_q;
        case (alu_op_e'(alu_op))
            ALU_PASS:   alu_res_s = alu_b_q;
            ALU_ADD:    alu_res_s = alu_a_q + alu_b_q;
            ALU_SUB:    alu_res_s = alu_a_q - alu_b_q;
            ALU_MULT:   alu_res_s = mult_full_s[DW-1:0];
            ALU_LSHIFT: alu_res_s = {alu_a_q[DW-2:0], 1'b0};
            default:    alu_res_s = alu_b_q;
        endcase
    end

    // AC next state: clr > ALU result > bus load > increment.
    always_comb begin
        ac_d = ac_q;
        if (clr_en[DP_AC]) begin
            ac_d = '0;
        end else if (write_en[DP_ALU]) begin
            ac_d = alu_res_s;
        end else if (write_en[DP_AC]) begin
            ac_d = bus_s;
        end else if (inc_en[DP_AC]) begin
            ac_d = ac_q + DW'(1'b1);
        end else begin
            ac_d = ac_q;
        end
    end

    // AC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ac_q <= '0;
        end else begin
            ac_q <= ac_d;
        end
    end

    // ALU operand latch; cleared only by reset, otherwise holds until re-latched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
        end else if (write_en[DP_LATCH]) begin
            alu_a_q <= ac_q;
            alu_b_q <= r_q;
        end else begin
            alu_a_q <= alu_a_q;
            alu_b_q <= alu_b_q;
        end
    end

    assign im_addr     = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = bus_s;
    assign dm_we       = write_en[DP_DM];
    assign instruction = ir_q[5:0];
    assign z           = (ac_q == '0) ? 16'd1 : 16'd0;

endmodule : datapath_bus

// File: tb/tb_datapath_bus.sv
// tb_datapath_bus
//   Directed bench for datapath_bus. Register contents are observed by
//   selecting them onto the bus and reading dm_wdata.
module tb_datapath_bus;
    import dp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  read_en;
    logic [15:0] write_en;
    logic [15:0] inc_en;
    logic [15:0] clr_en;
    logic [2:0]  alu_op;
    logic [7:0]  im_addr;
    logic [15:0] im_rdata;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic [15:0] dm_rdata;
    logic [5:0]  instruction;
    logic [15:0] z;

    int n_checks = 0;
    int n_fail   = 0;

    datapath_bus #(.DW(16), .PCW(8), .AW(8)) dut (
        .clk (clk), .rst_n (rst_n),
        .read_en (read_en), .write_en (write_en), .inc_en (inc_en), .clr_en (clr_en),
        .alu_op (alu_op),
        .im_addr (im_addr), .im_rdata (im_rdata),
        .dm_addr (dm_addr), .dm_wdata (dm_wdata), .dm_we (dm_we), .dm_rdata (dm_rdata),
        .instruction (instruction), .z (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] we;
        logic [15:0] inc;
        logic [15:0] clr;
        logic [2:0]  op;
        logic [15:0] imd;
        logic [15:0] dmd;
        logic [3:0]  obs;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] b(input int i);
        return 16'd1 << i;
    endfunction

    function automatic vec_t mk(input logic [3:0] rd, input logic [15:0] we,
                                input logic [15:0] inc, input logic [15:0] clr,
                                input logic [2:0] op, input logic [15:0] imd,
                                input logic [15:0] dmd, input logic [3:0] obs,
                                input logic [15:0] exp);
        vec_t v;
        v.rd = rd; v.we = we; v.inc = inc; v.clr = clr; v.op = op;
        v.imd = imd; v.dmd = dmd; v.obs = obs; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one strobe cycle (called just after a negedge), then idle the strobes.
    task automatic step(input logic [3:0] rd, input logic [15:0] we, input logic [15:0] inc,
                        input logic [15:0] clr, input logic [2:0] op,
                        input logic [15:0] imd, input logic [15:0] dmd);
        read_en = rd; write_en = we; inc_en = inc; clr_en = clr; alu_op = op;
        im_rdata = imd; dm_rdata = dmd;
        @(posedge clk);
        @(negedge clk);
        read_en = 4'd0; write_en = 16'd0; inc_en = 16'd0; clr_en = 16'd0; alu_op = 3'd0;
    endtask

    // Put a register on the bus and sample it.
    task automatic peek(input logic [3:0] src, output logic [15:0] val);
        read_en = src;
        #1;
        val = dm_wdata;
    endtask

    task automatic load_dm(input int tgt, input logic [15:0] v);
        step(4'd12, b(tgt), 16'd0, 16'd0, 3'd0, 16'd0, v);
    endtask

    logic [15:0] val;

    initial begin
        rst_n = 1'b0; read_en = 4'd0; write_en = 16'd0; inc_en = 16'd0; clr_en = 16'd0;
        alu_op = 3'd0; im_rdata = 16'd0; dm_rdata = 16'd0;

        // Reset held for two cycles.
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_z", z, 16'd1);
        check("rst_im_addr", {8'd0, im_addr}, 16'd0);
        check("rst_dm_addr", {8'd0, dm_addr}, 16'd0);
        check("rst_instr", {10'd0, instruction}, 16'd0);
        peek(4'd5, val); check("rst_ac", val, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        peek(4'd6, val); check("idle_r", val, 16'd0);
        check("idle_im_addr", {8'd0, im_addr}, 16'd0);
        check("idle_z", z, 16'd1);

        // Fetch: IR from instruction memory, then PC increment.
        step(4'd13, b(DP_IR), 16'd0, 16'd0, 3'd0, 16'h0013, 16'd0);
        check("fetch_instr", {10'd0, instruction}, 16'd19);
        step(4'd0, 16'd0, b(DP_PC), 16'd0, 3'd0, 16'd0, 16'd0);
        check("fetch_pc", {8'd0, im_addr}, 16'd1);

        // Table: rd, we, inc, clr, op, imd, dmd, observe-src, expected.
        tbl.push_back(mk(4'd12, b(DP_AC), 16'd0, 16'd0, 3'd0, 16'd0, 16'h0007, 4'd5, 16'h0007));
        tbl.push_back(mk(4'd12, b(DP_R), 16'd0, 16'd0, 3'd0, 16'd0, 16'h0005, 4'd6, 16'h0005));
        tbl.push_back(mk(4'd0, b(DP_LATCH), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd5, 16'h0007));
        tbl.push_back(mk(4'd0, b(DP_ALU), 16'd0, 16'd0, 3'd2, 16'd0, 16'd0, 4'd5, 16'h0002));
        tbl.push_back(mk(4'd12, b(DP_AC), 16'd0, 16'd0, 3'd0, 16'd0, 16'h0007, 4'd5, 16'h0007));
        tbl.push_back(mk(4'd0, b(DP_LATCH), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd6, 16'h0005));
        tbl.push_back(mk(4'd0, b(DP_ALU), 16'd0, 16'd0, 3'd3, 16'd0, 16'd0, 4'd5, 16'h0023));
        tbl.push_back(mk(4'd12, b(DP_AC), 16'd0, 16'd0, 3'd0, 16'd0, 16'h8001, 4'd5, 16'h8001));
        tbl.push_back(mk(4'd0, b(DP_LATCH), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd5, 16'h8001));
        tbl.push_back(mk(4'd0, b(DP_ALU), 16'd0, 16'd0, 3'd4, 16'd0, 16'd0, 4'd5, 16'h0002));
        tbl.push_back(mk(4'd12, b(DP_AC), 16'd0, 16'd0, 3'd0, 16'd0, 16'h0004, 4'd5, 16'h0004));
        tbl.push_back(mk(4'd5, b(DP_AR), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd2, 16'h0004));
        tbl.push_back(mk(4'd12, b(DP_R1) | b(DP_R2), 16'd0, 16'd0, 3'd0, 16'd0, 16'h1234, 4'd7, 16'h1234));
        tbl.push_back(mk(4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd8, 16'h1234));
        tbl.push_back(mk(4'd12, b(DP_R3), b(DP_R4), 16'd0, 3'd0, 16'd0, 16'h5678, 4'd9, 16'h5678));
        tbl.push_back(mk(4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd10, 16'h0001));
        tbl.push_back(mk(4'd12, b(DP_AC), 16'd0, 16'd0, 3'd0, 16'd0, 16'hFFFF, 4'd5, 16'hFFFF));
        tbl.push_back(mk(4'd0, 16'd0, b(DP_AC), 16'd0, 3'd0, 16'd0, 16'd0, 4'd5, 16'h0000));
        tbl.push_back(mk(4'd12, b(DP_PC), b(DP_PC), b(DP_PC), 3'd0, 16'd0, 16'h00AA, 4'd1, 16'h0000));
        tbl.push_back(mk(4'd12, b(DP_PC), b(DP_PC), 16'd0, 3'd0, 16'd0, 16'h00AA, 4'd1, 16'h00AA));
        tbl.push_back(mk(4'd12, b(DP_PC), 16'd0, 16'd0, 3'd0, 16'd0, 16'h12FF, 4'd1, 16'h00FF));
        tbl.push_back(mk(4'd0, 16'd0, b(DP_PC), 16'd0, 3'd0, 16'd0, 16'd0, 4'd1, 16'h0000));
        // ALU->AC beats bus->AC; latched operands are still 8001 and 5.
        tbl.push_back(mk(4'd12, b(DP_AC) | b(DP_ALU), 16'd0, 16'd0, 3'd1, 16'd0, 16'h1111, 4'd5, 16'h8006));
        tbl.push_back(mk(4'd12, b(DP_AC), 16'd0, b(DP_AC), 3'd0, 16'd0, 16'h4321, 4'd5, 16'h0000));
        tbl.push_back(mk(4'd0, b(DP_ALU), 16'd0, 16'd0, 3'd6, 16'd0, 16'd0, 4'd5, 16'h0005));
        tbl.push_back(mk(4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd14, 16'h0000));
        tbl.push_back(mk(4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd3, 16'h0000));
        tbl.push_back(mk(4'd13, b(DP_IR), 16'd0, 16'd0, 3'd0, 16'h00C0, 16'd0, 4'd4, 16'h00C0));
        tbl.push_back(mk(4'd2, b(DP_R3), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd9, 16'h0004));
        tbl.push_back(mk(4'd7, b(DP_R), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 4'd6, 16'h1234));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rd, tbl[i].we, tbl[i].inc, tbl[i].clr, tbl[i].op, tbl[i].imd, tbl[i].dmd);
            peek(tbl[i].obs, val);
            check($sformatf("vec%0d", i), val, tbl[i].exp);
        end

        // Memory path: AR from AC, DM write strobe and data, DM read into AC.
        load_dm(DP_AC, 16'h0004);
        step(4'd5, b(DP_AR), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0);
        check("mem_dm_addr", {8'd0, dm_addr}, 16'h0004);
        load_dm(DP_AC, 16'hBEEF);
        read_en = 4'd5; write_en = b(DP_DM);
        #1;
        check("mem_dm_we", {15'd0, dm_we}, 16'd1);
        check("mem_dm_wdata", dm_wdata, 16'hBEEF);
        @(posedge clk); @(negedge clk);
        read_en = 4'd0; write_en = 16'd0;
        #1;
        check("mem_dm_we_off", {15'd0, dm_we}, 16'd0);
        load_dm(DP_AC, 16'd0);
        load_dm(DP_AC, 16'hBEEF);
        peek(4'd5, val); check("mem_ac_from_dm", val, 16'hBEEF);
        check("mem_z_nonzero", z, 16'd0);

        // AC wrap sets z.
        load_dm(DP_AC, 16'hFFFF);
        step(4'd0, 16'd0, b(DP_AC), 16'd0, 3'd0, 16'd0, 16'd0);
        check("wrap_z", z, 16'd1);

        // Reset mid-operation discards latched operands and ignores strobes.
        load_dm(DP_AC, 16'h0003);
        load_dm(DP_R, 16'h0004);
        step(4'd0, b(DP_LATCH), 16'd0, 16'd0, 3'd0, 16'd0, 16'd0);
        rst_n = 1'b0;
        step(4'd12, b(DP_AC) | b(DP_R), 16'd0, 16'd0, 3'd0, 16'd0, 16'h0009);
        rst_n = 1'b1;
        peek(4'd6, val); check("midrst_r", val, 16'd0);
        step(4'd0, b(DP_ALU), 16'd0, 16'd0, 3'd1, 16'd0, 16'd0);
        peek(4'd5, val); check("midrst_ac", val, 16'd0);
        check("midrst_z", z, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_datapath_bus
